// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, slot ranges and the per-slot bit selector.
package i2s_pkg;

    localparam int unsigned SAMPLE_W    = 16;
    localparam int unsigned SLOT_BITS   = 32;
    localparam int unsigned FRAME_SLOTS = 64;
    localparam int unsigned SLOT_W      = $clog2(FRAME_SLOTS);
    localparam int unsigned BIT_W       = $clog2(SAMPLE_W);

    localparam logic [SLOT_W-1:0] LEFT_FIRST  = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] LEFT_LAST   = SLOT_W'(1 + SAMPLE_W - 1);
    localparam logic [SLOT_W-1:0] RIGHT_FIRST = SLOT_W'(SLOT_BITS + 1);
    localparam logic [SLOT_W-1:0] RIGHT_LAST  = SLOT_W'(SLOT_BITS + SAMPLE_W);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } sample_pair_t;

    // Bit driven during slot n: MSB one slot after each LRCLK edge, zero padding elsewhere.
    function automatic logic frame_bit(sample_pair_t f, logic [SLOT_W-1:0] n);
        logic [BIT_W-1:0] idx;
        frame_bit = 1'b0;
        idx       = '0;
        if (n >= LEFT_FIRST && n <= LEFT_LAST) begin
            idx       = BIT_W'(n - LEFT_FIRST);
            frame_bit = f.left[~idx];
        end else if (n >= RIGHT_FIRST && n <= RIGHT_LAST) begin
            idx       = BIT_W'(n - RIGHT_FIRST);
            frame_bit = f.right[~idx];
        end
    endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-side bus between the audio source (master) and the I2S transmitter (slave).
interface i2s_transmitter_if;
    import i2s_pkg::*;

    sample_t left_sample;
    sample_t right_sample;
    logic    sample_valid;
    logic    sample_req;
    logic    underrun;

    modport master (
        output left_sample, right_sample, sample_valid,
        input  sample_req, underrun
    );

    modport slave (
        input  left_sample, right_sample, sample_valid,
        output sample_req, underrun
    );
endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider and 64-slot counter; shareable with the I2S receiver.
// BCLK_DIV must be even and >= 4.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV = 24
) (
    input  logic              clk_in,
    input  logic              rst_in,
    output logic              bclk_o,
    output logic              fall_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic [SLOT_W-1:0] slot_next_o
);

    localparam int unsigned HALF  = BCLK_DIV / 2;
    localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
    logic              bclk_q, bclk_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              wrap;

    assign wrap        = (div_cnt_q == CNT_W'(HALF - 1));
    assign fall_o      = wrap & bclk_q;
    assign bclk_o      = bclk_q;
    assign slot_o      = slot_q;
    assign slot_next_o = slot_q + 1'b1;

    // Next-state: divider wrap toggles BCLK; slot advances on the 1->0 transition.
    always_comb begin
        div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        slot_d    = fall_o ? slot_next_o : slot_q;
    end

    // State registers; slot starts at 63 so the first falling edge lands on slot 0.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            slot_q    <= '1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            slot_q    <= slot_d;
        end
    end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S master transmitter: double-buffered 16-bit stereo, 32-bit slots, MSB first.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int unsigned BCLK_DIV           = 24,
    parameter bit          REPEAT_ON_UNDERRUN = 1'b1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    i2s_transmitter_if.slave   smp,
    output logic               i2s_bclk_out,
    output logic               i2s_lrclk_out,
    output logic               i2s_data_out
);

    logic              fall;
    logic [SLOT_W-1:0] slot_cur;
    logic [SLOT_W-1:0] slot_next;
    logic              load;

    sample_pair_t hold_q, hold_d;
    sample_pair_t frame_q, frame_d;
    logic         pending_q, pending_d;
    logic         lrclk_q, lrclk_d;
    logic         data_q, data_d;
    logic         req_q, req_d;
    logic         underrun_q, underrun_d;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .bclk_o      (i2s_bclk_out),
        .fall_o      (fall),
        .slot_o      (slot_cur),
        .slot_next_o (slot_next)
    );

    // Frame load happens on the falling edge that enters slot 0.
    assign load = fall && (slot_next == '0);

    // Next-state: serializer outputs, frame load and holding capture.
    always_comb begin
        hold_d     = hold_q;
        frame_d    = frame_q;
        pending_d  = pending_q;
        lrclk_d    = lrclk_q;
        data_d     = data_q;
        req_d      = 1'b0;
        underrun_d = 1'b0;

        if (fall) begin
            lrclk_d = slot_next[SLOT_W-1];
            // Slot 0 is always pad, so the outgoing frame is safe to use here.
            data_d  = frame_bit(frame_q, slot_next);
        end

        if (load) begin
            req_d     = 1'b1;
            pending_d = 1'b0;
            if (pending_q) begin
                frame_d = hold_q;
            end else begin
                underrun_d = 1'b1;
                frame_d    = REPEAT_ON_UNDERRUN ? hold_q : '0;
            end
        end

        // A strobe in the load cycle lands in holding for the following frame.
        if (smp.sample_valid) begin
            hold_d.left  = smp.left_sample;
            hold_d.right = smp.right_sample;
            pending_d    = 1'b1;
        end
    end

    // State registers; reset aborts any word in flight.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_q     <= '0;
            frame_q    <= '0;
            pending_q  <= 1'b0;
            lrclk_q    <= 1'b0;
            data_q     <= 1'b0;
            req_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            frame_q    <= frame_d;
            pending_q  <= pending_d;
            lrclk_q    <= lrclk_d;
            data_q     <= data_d;
            req_q      <= req_d;
            underrun_q <= underrun_d;
        end
    end

    assign i2s_lrclk_out  = lrclk_q;
    assign i2s_data_out   = data_q;
    assign smp.sample_req = req_q;
    assign smp.underrun   = underrun_q;

endmodule
